// File: rtl/rs_pkg.sv
// rs_pkg: shared opcodes, the load/store classification helper and the
// reference entry layout used by the rs_param reservation station.
package rs_pkg;

   localparam int RS_XLEN  = 32;
   localparam int RS_OP_W  = 5;
   localparam int RS_TAG_W = 3;

   // ALU-class opcodes
   localparam int unsigned OP_ADD  = 0;
   localparam int unsigned OP_SUB  = 1;
   localparam int unsigned OP_AND  = 2;
   localparam int unsigned OP_OR   = 3;
   localparam int unsigned OP_XOR  = 4;
   localparam int unsigned OP_SLL  = 5;
   localparam int unsigned OP_SRL  = 6;
   localparam int unsigned OP_SRA  = 7;
   localparam int unsigned OP_SLT  = 8;
   localparam int unsigned OP_SLTU = 9;
   localparam int unsigned OP_LUI  = 10;
   localparam int unsigned OP_BEQ  = 11;
   localparam int unsigned OP_BNE  = 12;
   localparam int unsigned OP_BLT  = 13;
   localparam int unsigned OP_BGE  = 14;
   localparam int unsigned OP_BLTU = 15;

   // MEM-class opcodes occupy the contiguous range LB..SW
   localparam int unsigned OP_LB   = 18;
   localparam int unsigned OP_LH   = 19;
   localparam int unsigned OP_LW   = 20;
   localparam int unsigned OP_LBU  = 21;
   localparam int unsigned OP_LHU  = 22;
   localparam int unsigned OP_SB   = 23;
   localparam int unsigned OP_SH   = 24;
   localparam int unsigned OP_SW   = 25;

   // All-ones opcode is a bubble that never allocates
   localparam int unsigned OP_NOP  = (1 << RS_OP_W) - 1;

   // Reference layout of one station entry at the default widths
   typedef struct packed {
      logic                busy;
      logic [RS_OP_W-1:0]  op;
      logic [RS_XLEN-1:0]  v1;
      logic [RS_XLEN-1:0]  v2;
      logic [RS_TAG_W-1:0] q1;
      logic [RS_TAG_W-1:0] q2;
      logic [RS_TAG_W-1:0] des;
      logic [RS_XLEN-1:0]  imm;
   } rs_entry_t;

   // True for loads and stores, which are steered to the MEM partition
   function automatic logic is_mem_op(input int unsigned op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

endpackage

// File: rtl/rs_partition.sv
// rs_partition: one partition of the reservation station. Holds DEPTH
// entries, snoops both CDB ports for operand wakeup (and dispatch bypass),
// picks the lowest free slot for allocation and an eligible entry for the
// issue register. Optional macro RS_AGE_ORDER_EN adds an age matrix so the
// oldest eligible entry issues first instead of the lowest index.
module rs_partition
   import rs_pkg::*;
#(
   parameter int XLEN    = RS_XLEN,
   parameter int OP_W    = RS_OP_W,
   parameter int TAG_W   = RS_TAG_W,
   parameter int DEPTH   = 3,
   parameter bit HAS_IMM = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_alloc,
   output logic                       o_has_free,
   input  logic [OP_W-1:0]            i_op,
   input  logic [XLEN-1:0]            i_v1,
   input  logic [XLEN-1:0]            i_v2,
   input  logic [TAG_W-1:0]           i_q1,
   input  logic [TAG_W-1:0]           i_q2,
   input  logic [XLEN-1:0]            i_imm,
   input  logic [TAG_W-1:0]           i_des,
   input  logic                       i_cdb0_valid,
   input  logic [TAG_W-1:0]           i_cdb0_tag,
   input  logic [XLEN-1:0]            i_cdb0_data,
   input  logic                       i_cdb1_valid,
   input  logic [TAG_W-1:0]           i_cdb1_tag,
   input  logic [XLEN-1:0]            i_cdb1_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [OP_W-1:0]            o_op,
   output logic [XLEN-1:0]            o_v1,
   output logic [XLEN-1:0]            o_v2,
   output logic [XLEN-1:0]            o_imm,
   output logic [TAG_W-1:0]           o_des,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int CNT_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic             busy;
      logic [OP_W-1:0]  op;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
      logic [TAG_W-1:0] q1;
      logic [TAG_W-1:0] q2;
      logic [TAG_W-1:0] des;
      logic [XLEN-1:0]  imm;
   } entry_t;

   logic [DEPTH-1:0] w_busy;
   logic [DEPTH-1:0] w_elig;
   logic [DEPTH-1:0] w_free_oh;
   logic [DEPTH-1:0] w_alloc_oh;
   logic [DEPTH-1:0] w_pick;
   logic [DEPTH-1:0] w_sel_oh;
   logic [DEPTH-1:0] w_issue_oh;
   logic [OP_W-1:0]  w_op  [DEPTH];
   logic [XLEN-1:0]  w_v1  [DEPTH];
   logic [XLEN-1:0]  w_v2  [DEPTH];
   logic [XLEN-1:0]  w_imm [DEPTH];
   logic [TAG_W-1:0] w_des [DEPTH];
   logic             w_load;
   logic             w_issue;
   logic [OP_W-1:0]  w_sel_op;
   logic [XLEN-1:0]  w_sel_v1;
   logic [XLEN-1:0]  w_sel_v2;
   logic [XLEN-1:0]  w_sel_imm;
   logic [TAG_W-1:0] w_sel_des;
   logic [CNT_W-1:0] w_count;

   logic             r_valid;
   logic [OP_W-1:0]  r_op;
   logic [XLEN-1:0]  r_v1;
   logic [XLEN-1:0]  r_v2;
   logic [XLEN-1:0]  r_imm;
   logic [TAG_W-1:0] r_des;

   // Returns {tag, value} after snooping both CDBs; CDB0 wins on a shared tag.
   function automatic logic [TAG_W+XLEN-1:0] snoop(input logic [TAG_W-1:0] q,
                                                   input logic [XLEN-1:0]  v);
      logic [TAG_W+XLEN-1:0] res;
      res = {q, v};
      if (q != '0) begin
         if (i_cdb0_valid && (i_cdb0_tag == q))
            res = {{TAG_W{1'b0}}, i_cdb0_data};
         else if (i_cdb1_valid && (i_cdb1_tag == q))
            res = {{TAG_W{1'b0}}, i_cdb1_data};
      end
      return res;
   endfunction

   // Flush kills allocation and issue for the cycle it is asserted.
   assign w_alloc_oh = (i_alloc && !i_flush) ? w_free_oh : '0;
   assign w_load     = !r_valid || i_ready;
   assign w_issue    = !i_flush && w_load && (|w_elig);
   assign w_issue_oh = w_issue ? w_sel_oh : '0;
   assign o_has_free = |(~w_busy);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         entry_t r_ent;

         assign w_busy[gi] = r_ent.busy;
         assign w_elig[gi] = r_ent.busy && (r_ent.q1 == '0) && (r_ent.q2 == '0);
         assign w_op[gi]   = r_ent.op;
         assign w_v1[gi]   = r_ent.v1;
         assign w_v2[gi]   = r_ent.v2;
         assign w_imm[gi]  = r_ent.imm;
         assign w_des[gi]  = r_ent.des;

         // Entry state: allocate with bypass, wake up on CDB, free on issue
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_ent <= '0;
            end else if (i_flush) begin
               r_ent.busy <= 1'b0;
            end else if (w_alloc_oh[gi]) begin
               r_ent.busy             <= 1'b1;
               r_ent.op               <= i_op;
               {r_ent.q1, r_ent.v1}   <= snoop(i_q1, i_v1);
               {r_ent.q2, r_ent.v2}   <= snoop(i_q2, i_v2);
               r_ent.des              <= i_des;
               r_ent.imm              <= HAS_IMM ? i_imm : '0;
            end else if (r_ent.busy) begin
               {r_ent.q1, r_ent.v1}   <= snoop(r_ent.q1, r_ent.v1);
               {r_ent.q2, r_ent.v2}   <= snoop(r_ent.q2, r_ent.v2);
               if (w_issue_oh[gi])
                  r_ent.busy <= 1'b0;
            end
         end
      end
   endgenerate

   // Lowest-index free slot (descending scan so the lowest index wins)
   always_comb begin
      w_free_oh = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (!w_busy[i]) w_free_oh = DEPTH'(1) << i;
   end

`ifdef RS_AGE_ORDER_EN
   logic [DEPTH-1:0] r_age [DEPTH];

   // Row i records which entries were allocated after entry i
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
      end else if (!i_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc_oh[i] || w_issue_oh[i])
               r_age[i] <= '0;
            else
               r_age[i] <= r_age[i] | w_alloc_oh;
         end
      end
   end

   // An eligible entry is oldest when every other eligible entry is younger
   always_comb begin
      w_pick = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_pick[i] = w_elig[i];
         for (int j = 0; j < DEPTH; j++)
            if ((j != i) && w_elig[j] && !r_age[i][j]) w_pick[i] = 1'b0;
      end
   end
`else
   assign w_pick = w_elig;
`endif

   // Reduce the candidate set to one entry, lowest index first
   always_comb begin
      w_sel_oh = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (w_pick[i]) w_sel_oh = DEPTH'(1) << i;
   end

   // Mux the selected entry's payload toward the issue register
   always_comb begin
      w_sel_op  = '1;
      w_sel_v1  = '0;
      w_sel_v2  = '0;
      w_sel_imm = '0;
      w_sel_des = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_sel_oh[i]) begin
            w_sel_op  = w_op[i];
            w_sel_v1  = w_v1[i];
            w_sel_v2  = w_v2[i];
            w_sel_imm = w_imm[i];
            w_sel_des = w_des[i];
         end
      end
   end

   // Issue register: reload when empty or consumed, otherwise hold
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_op    <= '1;
         r_v1    <= '0;
         r_v2    <= '0;
         r_imm   <= '0;
         r_des   <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (w_load) begin
         if (w_issue) begin
            r_valid <= 1'b1;
            r_op    <= w_sel_op;
            r_v1    <= w_sel_v1;
            r_v2    <= w_sel_v2;
            r_imm   <= w_sel_imm;
            r_des   <= w_sel_des;
         end else begin
            r_valid <= 1'b0;
            r_des   <= '0;
         end
      end
   end

   // Occupancy is the popcount of registered busy bits
   always_comb begin
      w_count = '0;
      for (int i = 0; i < DEPTH; i++)
         w_count = w_count + CNT_W'(w_busy[i]);
   end

   assign o_valid = r_valid;
   assign o_op    = r_op;
   assign o_v1    = r_v1;
   assign o_v2    = r_v2;
   assign o_imm   = r_imm;
   assign o_des   = r_des;
   assign o_count = w_count;

endmodule

// File: rtl/rs_param.sv
// rs_param: reservation station top. Classifies dispatched ops into the ALU
// or MEM partition and exposes both issue ports. Optional macro
// RS_AGE_ORDER_EN (handled inside rs_partition) selects oldest-first issue.
module rs_param
   import rs_pkg::*;
#(
   parameter int XLEN      = RS_XLEN,
   parameter int OP_W      = RS_OP_W,
   parameter int TAG_W     = RS_TAG_W,
   parameter int ALU_DEPTH = 3,
   parameter int MEM_DEPTH = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           dispatch_valid,
   output logic                           dispatch_ready,
   input  logic [OP_W-1:0]                dispatch_op,
   input  logic [XLEN-1:0]                dispatch_v1,
   input  logic [XLEN-1:0]                dispatch_v2,
   input  logic [TAG_W-1:0]               dispatch_q1,
   input  logic [TAG_W-1:0]               dispatch_q2,
   input  logic [XLEN-1:0]                dispatch_imm,
   input  logic [TAG_W-1:0]               dispatch_des,
   input  logic                           cdb0_valid,
   input  logic [TAG_W-1:0]               cdb0_tag,
   input  logic [XLEN-1:0]                cdb0_data,
   input  logic                           cdb1_valid,
   input  logic [TAG_W-1:0]               cdb1_tag,
   input  logic [XLEN-1:0]                cdb1_data,
   output logic                           alu_valid,
   input  logic                           alu_ready,
   output logic [OP_W-1:0]                alu_op,
   output logic [XLEN-1:0]                alu_v1,
   output logic [XLEN-1:0]                alu_v2,
   output logic [TAG_W-1:0]               alu_des,
   output logic                           mem_valid,
   input  logic                           mem_ready,
   output logic [OP_W-1:0]                mem_op,
   output logic [XLEN-1:0]                mem_v1,
   output logic [XLEN-1:0]                mem_v2,
   output logic [XLEN-1:0]                mem_imm,
   output logic [TAG_W-1:0]               mem_des,
   output logic [$clog2(ALU_DEPTH+1)-1:0] alu_count,
   output logic [$clog2(MEM_DEPTH+1)-1:0] mem_count
);

   logic            w_is_nop;
   logic            w_is_mem;
   logic            w_alu_free;
   logic            w_mem_free;
   logic            w_accept;
   logic [XLEN-1:0] w_alu_imm_unused;

   // NOPs fall into the ALU side for readiness but never allocate
   assign w_is_nop       = &dispatch_op;
   assign w_is_mem       = !w_is_nop && is_mem_op(32'(dispatch_op));
   assign dispatch_ready = !flush && (w_is_mem ? w_mem_free : w_alu_free);
   assign w_accept       = dispatch_valid && dispatch_ready && !w_is_nop;

   rs_partition #(
      .XLEN    (XLEN),
      .OP_W    (OP_W),
      .TAG_W   (TAG_W),
      .DEPTH   (ALU_DEPTH),
      .HAS_IMM (1'b0)
   ) u_alu (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (flush),
      .i_alloc      (w_accept && !w_is_mem),
      .o_has_free   (w_alu_free),
      .i_op         (dispatch_op),
      .i_v1         (dispatch_v1),
      .i_v2         (dispatch_v2),
      .i_q1         (dispatch_q1),
      .i_q2         (dispatch_q2),
      .i_imm        (dispatch_imm),
      .i_des        (dispatch_des),
      .i_cdb0_valid (cdb0_valid),
      .i_cdb0_tag   (cdb0_tag),
      .i_cdb0_data  (cdb0_data),
      .i_cdb1_valid (cdb1_valid),
      .i_cdb1_tag   (cdb1_tag),
      .i_cdb1_data  (cdb1_data),
      .o_valid      (alu_valid),
      .i_ready      (alu_ready),
      .o_op         (alu_op),
      .o_v1         (alu_v1),
      .o_v2         (alu_v2),
      .o_imm        (w_alu_imm_unused),
      .o_des        (alu_des),
      .o_count      (alu_count)
   );

   rs_partition #(
      .XLEN    (XLEN),
      .OP_W    (OP_W),
      .TAG_W   (TAG_W),
      .DEPTH   (MEM_DEPTH),
      .HAS_IMM (1'b1)
   ) u_mem (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (flush),
      .i_alloc      (w_accept && w_is_mem),
      .o_has_free   (w_mem_free),
      .i_op         (dispatch_op),
      .i_v1         (dispatch_v1),
      .i_v2         (dispatch_v2),
      .i_q1         (dispatch_q1),
      .i_q2         (dispatch_q2),
      .i_imm        (dispatch_imm),
      .i_des        (dispatch_des),
      .i_cdb0_valid (cdb0_valid),
      .i_cdb0_tag   (cdb0_tag),
      .i_cdb0_data  (cdb0_data),
      .i_cdb1_valid (cdb1_valid),
      .i_cdb1_tag   (cdb1_tag),
      .i_cdb1_data  (cdb1_data),
      .o_valid      (mem_valid),
      .i_ready      (mem_ready),
      .o_op         (mem_op),
      .o_v1         (mem_v1),
      .o_v2         (mem_v2),
      .o_imm        (mem_imm),
      .o_des        (mem_des),
      .o_count      (mem_count)
   );

endmodule

// File: doc/rs_param.md
Name: rs_param

Overview:
- Parametrised successor to the fixed 3+3 reservation station.
- Holds dispatched micro-ops in two partitions, ALU and MEM, each with configurable depth.
- Captures operand results from two common-data-bus (CDB) broadcast ports and issues ready ops to the ALU and memory unit over valid/ready handshakes.
- Adds flush, per-partition occupancy counts, same-cycle dispatch bypass and single-edge (posedge-only) operation.

Parameters:
- XLEN, 32, operand/immediate width
- OP_W, 5, opcode width; all-ones opcode = NOP
- TAG_W, 3, producer tag width; tag 0 = "operand present"
- ALU_DEPTH, 3, ALU partition entries (>=1)
- MEM_DEPTH, 3, MEM partition entries (>=1)

Ports:
- clk in 1 clock, all state on rising edge
- rst in 1 reset, asynchronous, active-low
- flush in 1 synchronous clear of all entries and issue registers
- dispatch_valid in 1 dispatch request
- dispatch_ready out 1 target partition has a free slot and flush=0 (combinational)
- dispatch_op in OP_W opcode
- dispatch_v1 / dispatch_v2 in XLEN operand values
- dispatch_q1 / dispatch_q2 in TAG_W operand producer tags
- dispatch_imm in XLEN immediate (kept for MEM only)
- dispatch_des in TAG_W destination tag
- cdb0_valid, cdb1_valid in 1 broadcast valid
- cdb0_tag, cdb1_tag in TAG_W broadcast tag
- cdb0_data, cdb1_data in XLEN broadcast data
- alu_valid out 1 ALU issue valid; alu_ready in 1
- alu_op out OP_W; alu_v1, alu_v2 out XLEN; alu_des out TAG_W
- mem_valid out 1 MEM issue valid; mem_ready in 1
- mem_op out OP_W; mem_v1, mem_v2, mem_imm out XLEN; mem_des out TAG_W
- alu_count out $clog2(ALU_DEPTH+1) busy ALU entries
- mem_count out $clog2(MEM_DEPTH+1) busy MEM entries

Behaviour:
- Reset (rst=0, async): all entries not busy; alu_valid=mem_valid=0; alu_op=mem_op=all-ones; all other issue outputs 0; counts 0.
- Classification: MEM class is op in [5'b10010 LB .. 5'b11001 SW] inclusive. Every other non-NOP op is ALU class.
- NOP with dispatch_valid: no allocation. dispatch_ready still reflects the ALU partition.
- Accept: dispatch_valid && dispatch_ready at an edge writes the lowest-index free entry of the target partition. The ALU partition ignores imm.
- Dispatch bypass: if dispatch_qN != 0 matches a valid CDB tag in the same cycle, store that CDB's data and set qN=0.
- Wakeup: every edge, each busy entry with qN != 0 matching a valid CDB tag captures the data and clears qN. CDB0 has priority if both CDBs carry the same tag.
- Eligibility is judged from registered state, so an entry is issuable the cycle after its last operand is captured.
- Issue register per partition is loadable when valid=0 or (valid && ready).
  - When loadable, select an eligible entry (q1=q2=0): lowest index by default.
  - Copy the entry to the outputs, set valid=1 and free the entry in the same edge.
  - If none is eligible, valid falls to 0 and alu_des/mem_des are driven to 0.
- Outputs are held stable while valid && !ready.
- Latency: dispatch at edge N with both tags 0 gives valid=1 after edge N+1.
- A slot freed at edge N is visible to dispatch_ready in the following cycle. There is no same-cycle free/alloc reuse.
- Full partition: dispatch_ready=0 and no state change from the dispatch.
- flush=1: clears all busy bits and both valid bits. It overrides dispatch, wakeup and issue in that cycle. Outputs other than valid hold their values.
- Counts equal the registered busy popcount and exclude the issue registers.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- Defined: each partition keeps a DEPTH×DEPTH age matrix, updated on allocate/free. Selection picks the oldest eligible entry.
- Undefined: lowest-index eligible entry, and no age state is synthesised.

Decomposition:
- Package rs_pkg: opcode localparams (ADD..BLTU, NOP=all-ones), function is_mem_op(op), and the entry struct {busy, op, v1, v2, q1, q2, des, imm}.
- One sub-module, rs_partition, parametrised by DEPTH and HAS_IMM. It contains the entry array, wakeup, free-slot pick, eligible pick, optional age matrix and issue register. The top instantiates it twice and does classification only.

Test Plan:
- ADD with q1=q2=0, v1=5, v2=7, des=2: alu_valid after edge N+1 with alu_v1=5, alu_v2=7, alu_des=2. alu_count returns to 0.
- LW with q1=3: no issue. cdb0 tag=3, data=0x100 gives mem_v1=0x100 one cycle after capture, with imm preserved.
- Dispatch SUB with q2=4 in the same cycle cdb1 tag=4, data=9: entry stores v2=9 and issues next cycle (bypass).
- Fill 3 ALU entries with q1=6: dispatch_ready=0 for ADD and 1 for SW. cdb0 tag=6 wakes all three; with alu_ready=0 the outputs hold, then all three drain one per cycle.
- flush asserted with mem_valid=1 and 2 busy entries: next cycle mem_valid=0, mem_count=0, and a concurrent dispatch is dropped.
- RS_AGE_ORDER_EN: dispatch entries A(q1=5), B(ready) then free A's slot order. Checks: oldest eligible issues first; the undefined build issues lowest index.
